// File: rtl/linescanner_capture_controller.sv
// Line-scan sensor capture controller: exposure sequencing, ADC load pulse, pixel stream and line markers.
// Optional line-length checking is enabled by defining LINESCANNER_LINE_LENGTH_CHECK_EN.
module linescanner_capture_controller #(
  parameter int DATA_WIDTH  = 8,
  parameter int LINE_PIXELS = 1024,
  parameter int T_CVC       = 48,
  parameter int T_CDS       = 7,
  parameter int T_SAMPLE    = 48,
  parameter int T_HOLD      = 6,
  parameter int T_LOAD_DLY  = 3
) (
  input  logic                  pixel_clock,
  input  logic                  n_reset,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  lval,
  input  logic                  end_adc,
  output logic                  rst_cvc,
  output logic                  rst_cds,
  output logic                  sample,
  output logic                  load_pulse,
  output logic [DATA_WIDTH-1:0] pixel_data,
  output logic                  pixel_valid,
  output logic                  line_start,
  output logic                  line_end,
  output logic [15:0]           line_count
`ifdef LINESCANNER_LINE_LENGTH_CHECK_EN
  ,
  output logic                  line_len_err
`endif
);

  // A counter loaded with N-1 expires on the N-th edge; zero-length waits behave as one cycle.
  localparam logic [7:0] CVC_LD    = (T_CVC      < 1) ? 8'd0 : 8'(T_CVC - 1);
  localparam logic [7:0] CDS_LD    = (T_CDS      < 1) ? 8'd0 : 8'(T_CDS - 1);
  localparam logic [7:0] SAMPLE_LD = (T_SAMPLE   < 1) ? 8'd0 : 8'(T_SAMPLE - 1);
  localparam logic [7:0] HOLD_LD   = (T_HOLD     < 1) ? 8'd0 : 8'(T_HOLD - 1);
  localparam logic [7:0] LOAD_LD   = (T_LOAD_DLY < 1) ? 8'd0 : 8'(T_LOAD_DLY - 1);

  if ((LINE_PIXELS < 1) || (LINE_PIXELS > 65535)) begin : g_line_pixels_range
    $error("LINE_PIXELS must be within 1..65535");
  end

  typedef enum logic [2:0] {
    EXP_IDLE = 3'd0, EXP_CVC = 3'd1, EXP_CDS = 3'd2,
    EXP_WAIT_ADC = 3'd3, EXP_SAMPLE = 3'd4, EXP_HOLD = 3'd5
  } exp_state_t;

  typedef enum logic [2:0] {
    LD_ARM = 3'd0, LD_WAIT_LVAL_LOW = 3'd1, LD_DELAY = 3'd2,
    LD_PULSE = 3'd3, LD_WAIT_ADC_LOW = 3'd4
  } ld_state_t;

  exp_state_t            exp_state_r, exp_state_s;
  ld_state_t             ld_state_r, ld_state_s;
  logic [7:0]            exp_cnt_r, exp_cnt_s, ld_cnt_r, ld_cnt_s;
  logic                  rst_cvc_r, rst_cvc_s, rst_cds_r, rst_cds_s;
  logic                  sample_r, sample_s, load_pulse_r, load_pulse_s;
  logic                  end_adc_r, end_adc_d_r, adc_rise_s;
  logic [DATA_WIDTH-1:0] pixel_data_r;
  logic                  lval_r, line_start_r, line_end_r;
  logic [15:0]           line_count_r;

  // Both FSMs see end_adc through the same register, so an edge reaches them in the same cycle.
  assign adc_rise_s = end_adc_r & ~end_adc_d_r;

  // State, counter and output registers for both FSMs.
  always_ff @(posedge pixel_clock) begin
    if (!n_reset) begin
      exp_state_r  <= EXP_IDLE;
      ld_state_r   <= LD_ARM;
      exp_cnt_r    <= 8'd0;
      ld_cnt_r     <= 8'd0;
      rst_cvc_r    <= 1'b1;
      rst_cds_r    <= 1'b1;
      sample_r     <= 1'b0;
      load_pulse_r <= 1'b0;
      end_adc_r    <= 1'b0;
      end_adc_d_r  <= 1'b0;
    end else begin
      exp_state_r  <= exp_state_s;
      ld_state_r   <= ld_state_s;
      exp_cnt_r    <= exp_cnt_s;
      ld_cnt_r     <= ld_cnt_s;
      rst_cvc_r    <= rst_cvc_s;
      rst_cds_r    <= rst_cds_s;
      sample_r     <= sample_s;
      load_pulse_r <= load_pulse_s;
      end_adc_r    <= end_adc;
      end_adc_d_r  <= end_adc_r;
    end
  end

  // Exposure next-state and shared wait counter.
  always_comb begin
    exp_state_s = exp_state_r;
    exp_cnt_s   = exp_cnt_r;
    case (exp_state_r)
      EXP_IDLE: begin
        if (enable) begin
          exp_state_s = EXP_CVC;
          exp_cnt_s   = CVC_LD;
        end else begin
          exp_cnt_s   = 8'd0;
        end
      end
      EXP_CVC: begin
        if (exp_cnt_r == 8'd0) begin
          exp_state_s = EXP_CDS;
          exp_cnt_s   = CDS_LD;
        end else begin
          exp_cnt_s   = exp_cnt_r - 8'd1;
        end
      end
      EXP_CDS: begin
        if (exp_cnt_r == 8'd0) begin
          exp_state_s = EXP_WAIT_ADC;
        end else begin
          exp_cnt_s   = exp_cnt_r - 8'd1;
        end
      end
      EXP_WAIT_ADC: begin
        if (end_adc_r) begin
          exp_state_s = EXP_SAMPLE;
          exp_cnt_s   = SAMPLE_LD;
        end else begin
          exp_cnt_s   = 8'd0;
        end
      end
      EXP_SAMPLE: begin
        if (exp_cnt_r == 8'd0) begin
          exp_state_s = EXP_HOLD;
          exp_cnt_s   = HOLD_LD;
        end else begin
          exp_cnt_s   = exp_cnt_r - 8'd1;
        end
      end
      EXP_HOLD: begin
        if (exp_cnt_r == 8'd0) begin
          exp_state_s = EXP_IDLE;
        end else begin
          exp_cnt_s   = exp_cnt_r - 8'd1;
        end
      end
      default: begin
        exp_state_s = EXP_IDLE;
        exp_cnt_s   = 8'd0;
      end
    endcase
  end

  // Exposure outputs follow the state being entered, so each edge lands on the transition clock.
  always_comb begin
    rst_cvc_s = (exp_state_s == EXP_IDLE);
    rst_cds_s = (exp_state_s == EXP_IDLE) || (exp_state_s == EXP_CVC);
    sample_s  = (exp_state_s == EXP_SAMPLE);
  end

  // Load FSM next-state; lval is qualified through the pixel register.
  always_comb begin
    ld_state_s = ld_state_r;
    ld_cnt_s   = ld_cnt_r;
    case (ld_state_r)
      LD_ARM: begin
        if (adc_rise_s) begin
          ld_state_s = lval_r ? LD_WAIT_LVAL_LOW : LD_DELAY;
          ld_cnt_s   = LOAD_LD;
        end else begin
          ld_cnt_s   = 8'd0;
        end
      end
      LD_WAIT_LVAL_LOW: begin
        if (!lval_r) begin
          ld_state_s = LD_DELAY;
          ld_cnt_s   = LOAD_LD;
        end else begin
          ld_cnt_s   = LOAD_LD;
        end
      end
      LD_DELAY: begin
        if (ld_cnt_r == 8'd0) begin
          ld_state_s = LD_PULSE;
        end else begin
          ld_cnt_s   = ld_cnt_r - 8'd1;
        end
      end
      LD_PULSE: begin
        ld_state_s = LD_WAIT_ADC_LOW;
      end
      LD_WAIT_ADC_LOW: begin
        if (!end_adc_r) begin
          ld_state_s = LD_ARM;
        end else begin
          ld_state_s = LD_WAIT_ADC_LOW;
        end
      end
      default: begin
        ld_state_s = LD_ARM;
        ld_cnt_s   = 8'd0;
      end
    endcase
  end

  // Load pulse output decode.
  always_comb begin
    load_pulse_s = (ld_state_s == LD_PULSE);
  end

  // Pixel stream, line markers and completed-line count.
  always_ff @(posedge pixel_clock) begin
    if (!n_reset) begin
      pixel_data_r <= '0;
      lval_r       <= 1'b0;
      line_start_r <= 1'b0;
      line_end_r   <= 1'b0;
      line_count_r <= 16'd0;
    end else begin
      pixel_data_r <= data;
      lval_r       <= lval;
      line_start_r <= lval & ~lval_r;
      line_end_r   <= lval_r & ~lval;
      if (lval_r && !lval) begin
        line_count_r <= line_count_r + 16'd1;
      end
    end
  end

`ifdef LINESCANNER_LINE_LENGTH_CHECK_EN
  localparam logic [15:0] LINE_PIXELS_W = 16'(LINE_PIXELS);
  logic [15:0] pix_cnt_r;
  logic        line_len_err_r;

  // Saturating per-line pixel count, judged when the line closes.
  always_ff @(posedge pixel_clock) begin
    if (!n_reset) begin
      pix_cnt_r      <= 16'd0;
      line_len_err_r <= 1'b0;
    end else begin
      if (lval && !lval_r) begin
        pix_cnt_r <= 16'd1;
      end else if (lval && (pix_cnt_r != 16'hFFFF)) begin
        pix_cnt_r <= pix_cnt_r + 16'd1;
      end
      line_len_err_r <= lval_r && !lval && (pix_cnt_r != LINE_PIXELS_W);
    end
  end

  assign line_len_err = line_len_err_r;
`endif

  assign rst_cvc     = rst_cvc_r;
  assign rst_cds     = rst_cds_r;
  assign sample      = sample_r;
  assign load_pulse  = load_pulse_r;
  assign pixel_data  = pixel_data_r;
  assign pixel_valid = lval_r;
  assign line_start  = line_start_r;
  assign line_end    = line_end_r;
  assign line_count  = line_count_r;

endmodule

// File: tb/tb_linescanner_capture_controller.sv
// Directed self-checking bench for linescanner_capture_controller (default parameters).
module tb_linescanner_capture_controller;

  logic        pixel_clock = 1'b0;
  logic        n_reset, enable, lval, end_adc;
  logic [7:0]  data;
  logic        rst_cvc, rst_cds, sample, load_pulse;
  logic [7:0]  pixel_data;
  logic        pixel_valid, line_start, line_end;
  logic [15:0] line_count;
`ifdef LINESCANNER_LINE_LENGTH_CHECK_EN
  logic        line_len_err;
`endif

  int total = 0;
  int bad   = 0;

  linescanner_capture_controller dut (
    .pixel_clock(pixel_clock), .n_reset(n_reset), .enable(enable), .data(data),
    .lval(lval), .end_adc(end_adc), .rst_cvc(rst_cvc), .rst_cds(rst_cds),
    .sample(sample), .load_pulse(load_pulse), .pixel_data(pixel_data),
    .pixel_valid(pixel_valid), .line_start(line_start), .line_end(line_end),
    .line_count(line_count)
`ifdef LINESCANNER_LINE_LENGTH_CHECK_EN
    , .line_len_err(line_len_err)
`endif
  );

  always #5 pixel_clock = ~pixel_clock;

  function automatic logic sig_of(input int which);
    case (which)
      0:       sig_of = rst_cvc;
      1:       sig_of = rst_cds;
      2:       sig_of = sample;
      3:       sig_of = load_pulse;
      default: sig_of = line_end;
    endcase
  endfunction

  // Number of falling edges advanced until the signal reaches val (limit on timeout).
  task automatic count_until(input int which, input logic val, input int limit, output int n);
    n = 0;
    while ((sig_of(which) !== val) && (n < limit)) begin
      @(negedge pixel_clock);
      n++;
    end
  endtask

  task automatic apply_reset();
    n_reset = 1'b0; enable = 1'b0; lval = 1'b0; end_adc = 1'b0; data = 8'h00;
    repeat (2) @(negedge pixel_clock);
    n_reset = 1'b1;
    @(negedge pixel_clock);
  endtask

  task automatic test_reset();
    n_reset = 1'b0; enable = 1'b0; lval = 1'b1; end_adc = 1'b0; data = 8'hA5;
    repeat (2) @(negedge pixel_clock);
    total++; if (rst_cvc !== 1'b1) begin bad++; $display("FAIL reset_rst_cvc got=%b want=1", rst_cvc); end
    total++; if (rst_cds !== 1'b1) begin bad++; $display("FAIL reset_rst_cds got=%b want=1", rst_cds); end
    total++; if (sample !== 1'b0) begin bad++; $display("FAIL reset_sample got=%b want=0", sample); end
    total++; if (load_pulse !== 1'b0) begin bad++; $display("FAIL reset_load_pulse got=%b want=0", load_pulse); end
    total++; if (pixel_valid !== 1'b0) begin bad++; $display("FAIL reset_pixel_valid got=%b want=0", pixel_valid); end
    total++; if (pixel_data !== 8'h00) begin bad++; $display("FAIL reset_pixel_data got=%h want=00", pixel_data); end
    total++; if ({line_start, line_end} !== 2'b00) begin bad++; $display("FAIL reset_markers got=%b want=00", {line_start, line_end}); end
    total++; if (line_count !== 16'd0) begin bad++; $display("FAIL reset_line_count got=%0d want=0", line_count); end
`ifdef LINESCANNER_LINE_LENGTH_CHECK_EN
    total++; if (line_len_err !== 1'b0) begin bad++; $display("FAIL reset_line_len_err got=%b want=0", line_len_err); end
`endif
    lval = 1'b0; n_reset = 1'b1;
    @(negedge pixel_clock);
    total++; if (pixel_data !== 8'hA5) begin bad++; $display("FAIL pixel_data_idle got=%h want=a5", pixel_data); end
    total++; if ({pixel_valid, rst_cvc} !== 2'b01) begin bad++; $display("FAIL idle_after_reset got=%b want=01", {pixel_valid, rst_cvc}); end
  endtask

  task automatic test_exposure();
    int n;
    apply_reset();
    enable = 1'b1;
    count_until(0, 1'b0, 10, n);
    total++; if (n != 1) begin bad++; $display("FAIL exp_cvc_start got=%0d want=1", n); end
    count_until(1, 1'b0, 200, n);
    total++; if (n != 48) begin bad++; $display("FAIL exp_t_cvc got=%0d want=48", n); end
    repeat (20) @(negedge pixel_clock);
    end_adc = 1'b1;
    count_until(2, 1'b1, 20, n);
    count_until(2, 1'b0, 200, n);
    total++; if (n != 48) begin bad++; $display("FAIL exp_t_sample got=%0d want=48", n); end
    end_adc = 1'b0;
    count_until(0, 1'b1, 50, n);
    total++; if (n != 6) begin bad++; $display("FAIL exp_t_hold got=%0d want=6", n); end
    total++; if ({rst_cds, sample} !== 2'b10) begin bad++; $display("FAIL exp_hold_end got=%b want=10", {rst_cds, sample}); end
    enable = 1'b0;
    repeat (5) @(negedge pixel_clock);
    total++; if (rst_cvc !== 1'b1) begin bad++; $display("FAIL exp_idle_blocked got=%b want=1", rst_cvc); end
  endtask

  task automatic test_load();
    int n;
    int pulses;
    apply_reset();
    lval = 1'b1;
    repeat (2) @(negedge pixel_clock);
    end_adc = 1'b1;
    repeat (10) @(negedge pixel_clock);
    lval = 1'b0;
    // lval is sampled on the next edge, then load_pulse follows 4 cycles later
    count_until(3, 1'b1, 50, n);
    total++; if (n != 5) begin bad++; $display("FAIL load_delay_lval got=%0d want=5", n); end
    @(negedge pixel_clock);
    total++; if (load_pulse !== 1'b0) begin bad++; $display("FAIL load_width got=%b want=0", load_pulse); end
    pulses = 0;
    repeat (10) begin
      @(negedge pixel_clock);
      if (load_pulse === 1'b1) pulses++;
    end
    total++; if (pulses != 0) begin bad++; $display("FAIL load_no_repeat got=%0d want=0", pulses); end
    end_adc = 1'b0;
    repeat (4) @(negedge pixel_clock);
    end_adc = 1'b1;
    count_until(3, 1'b1, 50, n);
    total++; if (n != 5) begin bad++; $display("FAIL load_delay_rearm got=%0d want=5", n); end
    end_adc = 1'b0;
  endtask

  task automatic test_line_full();
    int starts;
    int ends;
    logic [7:0] exp_d;
    apply_reset();
    starts = 0; ends = 0;
    lval = 1'b1; data = 8'h00;
    for (int i = 0; i < 1024; i++) begin
      @(negedge pixel_clock);
      exp_d = i[7:0];
      total++; if ({pixel_valid, pixel_data} !== {1'b1, exp_d}) begin bad++; $display("FAIL line_pixel_%0d got=%b/%h want=1/%h", i, pixel_valid, pixel_data, exp_d); end
      if (line_start === 1'b1) starts++;
      if (line_end === 1'b1) ends++;
      if (i < 1023) begin
        exp_d = 8'(i + 1);
        data  = exp_d;
      end else begin
        lval = 1'b0; data = 8'h3C;
      end
    end
    @(negedge pixel_clock);
    total++; if ({starts, ends} !== {32'd1, 32'd0}) begin bad++; $display("FAIL line_markers_in_line got=%0d/%0d want=1/0", starts, ends); end
    total++; if ({line_end, pixel_valid} !== 2'b10) begin bad++; $display("FAIL line_end_full got=%b want=10", {line_end, pixel_valid}); end
    total++; if (line_count !== 16'd1) begin bad++; $display("FAIL line_count_full got=%0d want=1", line_count); end
    total++; if (pixel_data !== 8'h3C) begin bad++; $display("FAIL line_tail_data got=%h want=3c", pixel_data); end
`ifdef LINESCANNER_LINE_LENGTH_CHECK_EN
    total++; if (line_len_err !== 1'b0) begin bad++; $display("FAIL line_len_err_full got=%b want=0", line_len_err); end
`endif
    @(negedge pixel_clock);
    total++; if (line_end !== 1'b0) begin bad++; $display("FAIL line_end_width got=%b want=0", line_end); end
  endtask

  task automatic test_line_short();
    lval = 1'b1;
    repeat (1023) @(negedge pixel_clock);
    lval = 1'b0;
    @(negedge pixel_clock);
    total++; if (line_end !== 1'b1) begin bad++; $display("FAIL short_line_end got=%b want=1", line_end); end
    total++; if (line_count !== 16'd2) begin bad++; $display("FAIL short_line_count got=%0d want=2", line_count); end
`ifdef LINESCANNER_LINE_LENGTH_CHECK_EN
    total++; if (line_len_err !== 1'b1) begin bad++; $display("FAIL short_line_len_err got=%b want=1", line_len_err); end
`endif
    @(negedge pixel_clock);
    lval = 1'b1;
    @(negedge pixel_clock);
    lval = 1'b0;
    total++; if ({line_start, pixel_valid} !== 2'b11) begin bad++; $display("FAIL single_start got=%b want=11", {line_start, pixel_valid}); end
    @(negedge pixel_clock);
    total++; if ({line_end, line_start, pixel_valid} !== 3'b100) begin bad++; $display("FAIL single_end got=%b want=100", {line_end, line_start, pixel_valid}); end
    total++; if (line_count !== 16'd3) begin bad++; $display("FAIL single_line_count got=%0d want=3", line_count); end
`ifdef LINESCANNER_LINE_LENGTH_CHECK_EN
    total++; if (line_len_err !== 1'b1) begin bad++; $display("FAIL single_line_len_err got=%b want=1", line_len_err); end
`endif
  endtask

  task automatic test_reset_mid();
    int n;
    int ends;
    apply_reset();
    enable = 1'b1;
    count_until(1, 1'b0, 100, n);
    end_adc = 1'b1;
    count_until(2, 1'b1, 100, n);
    total++; if (sample !== 1'b1) begin bad++; $display("FAIL mid_reach_sample got=%b want=1", sample); end
    lval = 1'b1;
    repeat (5) @(negedge pixel_clock);
    n_reset = 1'b0;
    @(negedge pixel_clock);
    total++; if ({sample, rst_cvc, rst_cds, pixel_valid} !== 4'b0110) begin bad++; $display("FAIL mid_reset_outputs got=%b want=0110", {sample, rst_cvc, rst_cds, pixel_valid}); end
    lval = 1'b0; enable = 1'b0; end_adc = 1'b0;
    @(negedge pixel_clock);
    n_reset = 1'b1;
    ends = 0;
    repeat (5) begin
      @(negedge pixel_clock);
      if (line_end === 1'b1) ends++;
    end
    total++; if (ends != 0) begin bad++; $display("FAIL mid_no_line_end got=%0d want=0", ends); end
    total++; if (line_count !== 16'd0) begin bad++; $display("FAIL mid_line_count got=%0d want=0", line_count); end
  endtask

  task automatic test_enable_drop();
    int n;
    int errs;
    apply_reset();
    enable = 1'b1;
    count_until(0, 1'b0, 10, n);
    enable = 1'b0;
    count_until(1, 1'b0, 100, n);
    total++; if (n != 48) begin bad++; $display("FAIL drop_t_cvc got=%0d want=48", n); end
    end_adc = 1'b1;
    // 7 CDS cycles, then WAIT_ADC sees the already-high end_adc one cycle later
    count_until(2, 1'b1, 50, n);
    total++; if (n != 8) begin bad++; $display("FAIL drop_sample_start got=%0d want=8", n); end
    count_until(2, 1'b0, 100, n);
    total++; if (n != 48) begin bad++; $display("FAIL drop_t_sample got=%0d want=48", n); end
    end_adc = 1'b0;
    count_until(0, 1'b1, 50, n);
    total++; if (n != 6) begin bad++; $display("FAIL drop_t_hold got=%0d want=6", n); end
    errs = 0;
    repeat (60) begin
      @(negedge pixel_clock);
      if ({rst_cvc, rst_cds, sample} !== 3'b110) errs++;
    end
    total++; if (errs != 0) begin bad++; $display("FAIL drop_stays_idle got=%0d want=0", errs); end
  endtask

  initial begin
    test_reset();
    test_exposure();
    test_load();
    test_line_full();
    test_line_short();
    test_reset_mid();
    test_enable_drop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
